// File: rtl/lcd_cfah_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cfah_pkg
// Purpose  : Shared types and constants for the CFAH/HD44780 LCD bus master.
// Revision : 1.0
// ============================================================================
package lcd_cfah_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_EN_HI    = 3'd2,
    S_HOLD     = 3'd3,
    S_BF_SETUP = 3'd4,
    S_BF_EN_HI = 3'd5,
    S_BF_HOLD  = 3'd6,
    S_DONE     = 3'd7
  } t_lcd_bm_state;

  localparam logic [7:0] c_CLEAR              = 8'h01;
  localparam logic [7:0] c_HOME               = 8'h02;
  localparam logic [7:0] c_ENTRY_MODE         = 8'h06;
  localparam logic [7:0] c_DISPLAY_ON         = 8'h0C;
  localparam logic [7:0] c_FUNCTION_SET_8B_2L = 8'h38;
  localparam logic [7:0] c_SET_DDRAM          = 8'h80;

  localparam int c_BF_BIT = 7;

  function automatic int f_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_cfah_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cfah_phase_timer
// Purpose  : Loadable down-counter; o_tc flags the last cycle of a phase.
// Revision : 1.0
// ============================================================================
module lcd_cfah_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_cnt;

  // Loading N leaves N-1 in the counter, so the phase spans exactly N cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val - WIDTH'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_cfah_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cfah_bus_master
// Purpose  : Timed RS/RW/EN/DATA cycles for a CFAH LCD, with busy-flag polling.
// Revision : 1.0
// ============================================================================
module lcd_cfah_bus_master
  import lcd_cfah_pkg::*;
#(
  parameter int G_T_SETUP     = 2,
  parameter int G_T_EN        = 12,
  parameter int G_T_HOLD      = 2,
  parameter int G_BF_POLL_MAX = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic       i_rnw,
  input  logic [7:0] i_wdata,
  input  logic       i_bf_poll_en,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_timeout,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  inout  wire  [7:0] io_lcd_data
);

  localparam int c_PH_W = $clog2(f_max3(G_T_SETUP, G_T_EN, G_T_HOLD) + 1);
  localparam int c_PC_W = $clog2(G_BF_POLL_MAX + 1);

  localparam logic [c_PH_W-1:0] c_T_SETUP  = c_PH_W'(G_T_SETUP);
  localparam logic [c_PH_W-1:0] c_T_EN     = c_PH_W'(G_T_EN);
  localparam logic [c_PH_W-1:0] c_T_HOLD   = c_PH_W'(G_T_HOLD);
  localparam logic [c_PC_W-1:0] c_POLL_MAX = c_PC_W'(G_BF_POLL_MAX);

  t_lcd_bm_state     r_state;
  logic              r_rnw;
  logic              r_poll_en;
  logic [7:0]        r_wdata;
  logic              r_bf;
  logic [c_PC_W-1:0] r_poll_cnt;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_rdata;
  logic              r_timeout;
  logic              r_lcd_rs;
  logic              r_lcd_rw;
  logic              r_lcd_en;

  logic              w_tmr_load;
  logic [c_PH_W-1:0] w_tmr_val;
  logic              w_tc;

  // Timer is reloaded with the length of the phase being entered.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = c_T_SETUP;
    case (r_state)
      S_IDLE: begin
        w_tmr_load = i_start;
        w_tmr_val  = c_T_SETUP;
      end
      S_SETUP, S_BF_SETUP: begin
        w_tmr_load = w_tc;
        w_tmr_val  = c_T_EN;
      end
      S_EN_HI, S_BF_EN_HI: begin
        w_tmr_load = w_tc;
        w_tmr_val  = c_T_HOLD;
      end
      S_HOLD, S_BF_HOLD: begin
        w_tmr_load = w_tc;
        w_tmr_val  = c_T_SETUP;
      end
      default: begin
        w_tmr_load = 1'b0;
        w_tmr_val  = c_T_SETUP;
      end
    endcase
  end

  lcd_cfah_phase_timer #(
    .WIDTH (c_PH_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rnw      <= 1'b1;
      r_poll_en  <= 1'b0;
      r_wdata    <= 8'h00;
      r_bf       <= 1'b0;
      r_poll_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rdata    <= 8'h00;
      r_timeout  <= 1'b0;
      r_lcd_rs   <= 1'b0;
      r_lcd_rw   <= 1'b1;
      r_lcd_en   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rnw      <= i_rnw;
            r_poll_en  <= i_bf_poll_en;
            r_wdata    <= i_wdata;
            r_poll_cnt <= '0;
            r_busy     <= 1'b1;
            r_timeout  <= 1'b0;
            r_lcd_rs   <= i_rs;
            r_lcd_rw   <= i_rnw;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_tc) begin
            r_lcd_en <= 1'b1;
            r_state  <= S_EN_HI;
          end
        end
        S_EN_HI: begin
          if (w_tc) begin
            r_lcd_en <= 1'b0;
            if (r_rnw) begin
              r_rdata <= io_lcd_data;
            end
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_tc) begin
            r_lcd_rs <= 1'b0;
            r_lcd_rw <= 1'b1;
            if (!r_rnw && r_poll_en) begin
              r_state <= S_BF_SETUP;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_BF_SETUP: begin
          if (w_tc) begin
            r_lcd_en <= 1'b1;
            r_state  <= S_BF_EN_HI;
          end
        end
        S_BF_EN_HI: begin
          if (w_tc) begin
            r_lcd_en <= 1'b0;
            r_bf     <= io_lcd_data[c_BF_BIT];
            if (r_poll_cnt != c_POLL_MAX) begin
              r_poll_cnt <= r_poll_cnt + c_PC_W'(1);
            end
            r_state <= S_BF_HOLD;
          end
        end
        S_BF_HOLD: begin
          if (w_tc) begin
            if (!r_bf) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (r_poll_cnt < c_POLL_MAX) begin
              r_state <= S_BF_SETUP;
            end else begin
              r_timeout <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Driver enable is rw itself, so release coincides with rw returning high.
  assign io_lcd_data = r_lcd_rw ? 8'hzz : r_wdata;

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rdata   = r_rdata;
  assign o_timeout = r_timeout;
  assign o_lcd_rs  = r_lcd_rs;
  assign o_lcd_rw  = r_lcd_rw;
  assign o_lcd_en  = r_lcd_en;

endmodule
`default_nettype wire

// File: doc/lcd_cfah_bus_master.md
# lcd_cfah_bus_master

Initiator for the CFAH/HD44780-style parallel LCD bus: turns single-word command requests into correctly timed RS/RW/EN/DATA cycles and polls the busy flag after every write. It is the DUT-side counterpart of the LCD CFAH emulator and sits between the AXI4-Lite LCD register slave and the `io_lcd_data/o_lcd_rw/o_lcd_en/o_lcd_rs` pins.

## Interface
- G_T_SETUP, 2: clk cycles RS/RW/DATA are stable before EN rises (≥1).
- G_T_EN, 12: clk cycles EN is high (≥1).
- G_T_HOLD, 2: clk cycles RS/RW/DATA are held after EN falls (≥1).
- G_BF_POLL_MAX, 1000: maximum busy-flag reads per write before timeout (≥1).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle request; sampled only in IDLE.
- i_rs  in  1  register select for the request (0 = instruction, 1 = data).
- i_rnw  in  1  1 = read cycle, 0 = write cycle.
- i_wdata  in  8  write data.
- i_bf_poll_en  in  1  1 = poll the busy flag after a write.
- o_busy  out  1  high from the cycle after an accepted start until o_done.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  8  last read data; valid when o_done is high after a read.
- o_timeout  out  1  qualifies o_done: poll limit reached.
- o_lcd_rs, o_lcd_rw, o_lcd_en  out  1 each  LCD control pins.
- io_lcd_data  inout  8  LCD data bus, driven only during writes.

## Operation
- Reset values: o_busy 0, o_done 0, o_rdata 0x00, o_timeout 0, o_lcd_rs 0, o_lcd_rw 1, o_lcd_en 0, io_lcd_data high-Z.
- States: IDLE, SETUP, EN_HI, HOLD, BF_SETUP, BF_EN_HI, BF_HOLD, DONE.
- IDLE + i_start: latch rs/rnw/wdata/poll_en, then go to SETUP. A start in any other state is ignored.
- SETUP, G_T_SETUP cycles: drive rs and rw. If rw=0, also drive the data. Then go to EN_HI.
- EN_HI, G_T_EN cycles: EN=1. On a read, sample io_lcd_data into o_rdata on the last EN_HI cycle.
- HOLD, G_T_HOLD cycles: EN=0, rs/rw/data unchanged. Next state:
  - write with poll_en=1 → BF_SETUP;
  - otherwise → DONE.
- BF_SETUP / BF_EN_HI / BF_HOLD: rs=0, rw=1, bus released, same phase lengths as above.
  - bit 7 is sampled on the last BF_EN_HI cycle; the poll counter increments once per read.
  - After BF_HOLD: bit7=0 → DONE. bit7=1 and count<G_BF_POLL_MAX → BF_SETUP. Otherwise set o_timeout and go to DONE.
- Busy-flag reads do not update o_rdata.
- DONE: o_done=1 for one cycle; o_timeout is valid in the same cycle. Return to IDLE with rs=0, rw=1, bus released. o_timeout clears on the next accepted start.
- Bus direction:
  - io_lcd_data is driven only while rw=0.
  - rw and rs change only while EN=0.
  - The data driver is released in the same cycle rw returns to 1.
- The phase counter is ⌈log2(max(G_T_SETUP,G_T_EN,G_T_HOLD)+1)⌉ bits wide. The poll counter is ⌈log2(G_BF_POLL_MAX+1)⌉ bits wide. Neither counter wraps.
- Reset asserted mid-cycle: all outputs immediately return to their reset values (EN drops asynchronously). No o_done is issued for the aborted request.

## Timing
- Start is accepted at edge 0; SETUP begins at edge 1.
- Access without polling: o_done is high in cycle 1+G_T_SETUP+G_T_EN+G_T_HOLD (17 with defaults).
- Each busy-flag poll adds G_T_SETUP+G_T_EN+G_T_HOLD cycles (16 with defaults).
- A write with k polls completes in 1+16·(k+1) cycles with defaults.
- Back-to-back: the earliest next start is accepted in the cycle after o_done, i.e. in IDLE.

## Structure
- Shared package `lcd_cfah_pkg`:
  - state enum `t_lcd_bm_state`;
  - instruction constants: CLEAR 0x01, HOME 0x02, ENTRY_MODE 0x06, DISPLAY_ON 0x0C, FUNCTION_SET_8B_2L 0x38, SET_DDRAM 0x80;
  - busy-flag bit index 7.
- Sub-module `lcd_cfah_phase_timer`: a loadable down-counter with a terminal-count flag, shared by the six timed states.
- The tri-state driver is one continuous assign in the top module.

## Test plan
- Write rs=0, data 0x38, poll disabled → emulator o_rdata=0x38 with RS=0; o_done at cycle 17; EN high for exactly 12 cycles.
- Write rs=1, data 0x41, poll enabled, emulator busy_flag_duration=40 → BF read until bit7=0; o_done with o_timeout=0; no data drive while rw=1.
- Read rs=1, emulator wdata_sel=1, wdata=0xA5 → o_rdata=0xA5 on o_done at cycle 17.
- G_BF_POLL_MAX=3, emulator holding BF=1 → exactly 3 BF reads, then o_done with o_timeout=1.
- i_start pulsed during EN_HI → ignored; only one emulator o_rdata_val and one o_done.
- rst_n asserted during EN_HI → EN=0, rw=1, bus high-Z immediately; no o_done; a new write after reset completes normally.
